// File: rtl/pattern_sweep_ctrl.sv
// Pattern sweep sequencer for trojan-detection benchmark runs.
// Walks every input pattern, samples the circuit and streams one record each.
module pattern_sweep_ctrl #(
  parameter int N_W    = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_W-1:0]   dut_in,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] gold_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_W-1:0]   rec_pattern,
  output logic [OUT_W-1:0] rec_dut,
  output logic             rec_mismatch,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [N_W:0]     mismatch_cnt,
  output logic             trojan_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_FINISH
  } state_t;

  localparam logic [N_W-1:0] LAST_PAT = '1;
  localparam logic [3:0] SET_LAST =
    4'(SETTLE > 0 ? SETTLE - 1 : 0);

  state_t             state_q;
  logic [3:0]         settle_q;
  logic [N_W-1:0]     dut_in_q;
  logic               rec_valid_q;
  logic [N_W-1:0]     rec_pattern_q;
  logic [OUT_W-1:0]   rec_dut_q;
  logic               rec_mis_q;
  logic               busy_q;
  logic               done_q;
  logic               aborted_q;
  logic [N_W:0]       mis_cnt_q;
  logic               trojan_q;
  logic               mis_d;

  assign mis_d = (dut_out != gold_out);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      settle_q      <= '0;
      dut_in_q      <= '0;
      rec_valid_q   <= 1'b0;
      rec_pattern_q <= '0;
      rec_dut_q     <= '0;
      rec_mis_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      mis_cnt_q     <= '0;
      trojan_q      <= 1'b0;
    end else if (state_q != S_IDLE && abort) begin
      // abort withdraws any pending record; partial counts stay visible
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rec_valid_q <= 1'b0;
      aborted_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            dut_in_q  <= '0;
            mis_cnt_q <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            trojan_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_APPLY;
          end
        end
        S_APPLY: begin
          settle_q <= '0;
          state_q  <= (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          if (settle_q == SET_LAST) begin
            state_q <= S_SAMPLE;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        S_SAMPLE: begin
          rec_dut_q     <= dut_out;
          rec_pattern_q <= dut_in_q;
          rec_mis_q     <= mis_d;
          rec_valid_q   <= 1'b1;
          if (mis_d) begin
            mis_cnt_q <= mis_cnt_q + (N_W+1)'(1);
            trojan_q  <= 1'b1;
          end
          state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (rec_ready) begin
            rec_valid_q <= 1'b0;
            if (dut_in_q == LAST_PAT) begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              dut_in_q <= dut_in_q + N_W'(1);
              state_q  <= S_APPLY;
            end
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_in       = dut_in_q;
  assign rec_valid    = rec_valid_q;
  assign rec_pattern  = rec_pattern_q;
  assign rec_dut      = rec_dut_q;
  assign rec_mismatch = rec_mis_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign mismatch_cnt = mis_cnt_q;
  assign trojan_flag  = trojan_q;

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// Scoreboard bench for pattern_sweep_ctrl: one instance with a settle
// delay and back-pressure, one with zero settle and start held high.
module tb_pattern_sweep_ctrl;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CK) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // instance A: N_W=2, OUT_W=1, SETTLE=1
  logic       reset, start, abort, rec_ready;
  logic [1:0] dut_in_a, rec_pattern_a;
  logic       dut_out_a, gold_out_a, rec_dut_a;
  logic       rec_valid_a, rec_mis_a;
  logic       busy_a, done_a, aborted_a, troj_flag_a;
  logic [2:0] mcnt_a;
  logic       gold_a [4];
  logic       troj_a [4];

  assign gold_out_a = gold_a[dut_in_a];
  assign dut_out_a  = gold_a[dut_in_a] ^ troj_a[dut_in_a];

  pattern_sweep_ctrl #(.N_W(2), .OUT_W(1), .SETTLE(1)) u_a (
    .CK(CK), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .gold_out(gold_out_a),
    .rec_valid(rec_valid_a), .rec_ready(rec_ready),
    .rec_pattern(rec_pattern_a), .rec_dut(rec_dut_a),
    .rec_mismatch(rec_mis_a), .busy(busy_a), .done(done_a),
    .aborted(aborted_a), .mismatch_cnt(mcnt_a),
    .trojan_flag(troj_flag_a)
  );

  // instance B: N_W=2, OUT_W=2, SETTLE=0
  logic       reset_b, start_b, abort_b, ready_b;
  logic [1:0] dut_in_b, rec_pattern_b;
  logic [1:0] dut_out_b, gold_out_b, rec_dut_b;
  logic       rec_valid_b, rec_mis_b;
  logic       busy_b, done_b, aborted_b, troj_flag_b;
  logic [2:0] mcnt_b;
  logic [1:0] gold_b [4];
  logic [1:0] troj_b [4];

  assign gold_out_b = gold_b[dut_in_b];
  assign dut_out_b  = gold_b[dut_in_b] ^ troj_b[dut_in_b];

  pattern_sweep_ctrl #(.N_W(2), .OUT_W(2), .SETTLE(0)) u_b (
    .CK(CK), .reset(reset_b), .start(start_b), .abort(abort_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .gold_out(gold_out_b),
    .rec_valid(rec_valid_b), .rec_ready(ready_b),
    .rec_pattern(rec_pattern_b), .rec_dut(rec_dut_b),
    .rec_mismatch(rec_mis_b), .busy(busy_b), .done(done_b),
    .aborted(aborted_b), .mismatch_cnt(mcnt_b),
    .trojan_flag(troj_flag_b)
  );

  typedef struct {
    int pat;
    int dut;
    int mis;
  } rec_t;
  rec_t exp_q[$];

  // reference: a sweep yields one record per pattern, in order
  function automatic void push_sweep(int upto);
    for (int p = 0; p < upto; p++) begin
      rec_t r;
      r.pat = p;
      r.dut = int'(gold_a[p] ^ troj_a[p]);
      r.mis = int'(troj_a[p]);
      exp_q.push_back(r);
    end
  endfunction

  function automatic int exp_mis(int upto);
    int n = 0;
    for (int p = 0; p < upto; p++) n += int'(troj_a[p]);
    return n;
  endfunction

  // monitor A: pops the scoreboard on every accepted record
  always @(negedge CK) begin
    if (reset && rec_valid_a && rec_ready) begin
      if (exp_q.size() == 0) begin
        chk("a_rec_unexpected", int'(rec_pattern_a), -1);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("a_rec_pattern", int'(rec_pattern_a), e.pat);
        chk("a_rec_dut", int'(rec_dut_a), e.dut);
        chk("a_rec_mismatch", int'(rec_mis_a), e.mis);
      end
    end
  end

  // monitor B: patterns cycle 0..3; gap 3 cycles, 5 across a restart
  int pat_b  = 0;
  int last_b = -1;
  int nrec_b = 0;
  always @(negedge CK) begin
    if (reset_b && rec_valid_b && ready_b) begin
      chk("b_rec_pattern", int'(rec_pattern_b), pat_b);
      chk("b_rec_dut", int'(rec_dut_b),
          int'(gold_b[pat_b] ^ troj_b[pat_b]));
      chk("b_rec_mismatch", int'(rec_mis_b),
          int'(troj_b[pat_b] != 2'b00));
      if (last_b >= 0)
        chk("b_rec_gap", cyc - last_b, (pat_b == 0) ? 5 : 3);
      last_b = cyc;
      pat_b  = (pat_b + 1) % 4;
      nrec_b++;
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic randomize_tables(bit with_troj);
    for (int p = 0; p < 4; p++) begin
      gold_a[p] = 1'($urandom_range(0, 1));
      troj_a[p] = with_troj ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic run_sweep(string tag, int stall, bit with_abort);
    int  n;
    bit  stalled;
    int  em;
    push_sweep(4);
    em = exp_mis(4);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk({tag, "_busy_start"}, int'(busy_a), 1);
    chk({tag, "_aborted_clr"}, int'(aborted_a), 0);
    chk({tag, "_dut_in0"}, int'(dut_in_a), 0);
    n = 0;
    stalled = 1'b0;
    while (!done_a && n < 400) begin
      if (stall > 0 && !stalled && rec_valid_a && rec_pattern_a == 2'd1) begin
        stalled = 1'b1;
        rec_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
          tick();
          n++;
          chk({tag, "_stall_valid"}, int'(rec_valid_a), 1);
          chk({tag, "_stall_pattern"}, int'(rec_pattern_a), 1);
          chk({tag, "_stall_dut_in"}, int'(dut_in_a), 1);
        end
        rec_ready = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    chk({tag, "_done_latency"}, n, 16 + stall);
    chk({tag, "_done"}, int'(done_a), 1);
    chk({tag, "_mismatch_cnt"}, int'(mcnt_a), em);
    chk({tag, "_trojan_flag"}, int'(troj_flag_a), int'(em != 0));
    chk({tag, "_final_dut_in"}, int'(dut_in_a), 3);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    tick();
    tick();
    chk({tag, "_busy_end"}, int'(busy_a), 0);
    chk({tag, "_done_sticky"}, int'(done_a), 1);
  endtask

  initial begin
    int n;
    int em;
    reset     = 1'b0;
    reset_b   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    start_b   = 1'b0;
    abort_b   = 1'b0;
    rec_ready = 1'b1;
    ready_b   = 1'b1;
    randomize_tables(1'b0);
    for (int p = 0; p < 4; p++) begin
      gold_b[p] = 2'($urandom_range(0, 3));
      troj_b[p] = 2'($urandom_range(0, 3));
    end
    troj_b[1] = 2'b01;

    tick();
    chk("rst_dut_in", int'(dut_in_a), 0);
    chk("rst_rec_valid", int'(rec_valid_a), 0);
    chk("rst_rec_pattern", int'(rec_pattern_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_aborted", int'(aborted_a), 0);
    chk("rst_mismatch_cnt", int'(mcnt_a), 0);
    chk("rst_trojan", int'(troj_flag_a), 0);
    reset   = 1'b1;
    reset_b = 1'b1;
    tick();

    // clean sweep
    run_sweep("s1", 0, 1'b0);

    // single mismatch on pattern 10, abort raised with start in IDLE
    randomize_tables(1'b0);
    troj_a[2] = 1'b1;
    run_sweep("s2", 0, 1'b1);

    // back-pressure on pattern 01
    randomize_tables(1'b1);
    run_sweep("s3", 5, 1'b0);

    // abort during SETTLE of pattern 10
    randomize_tables(1'b1);
    push_sweep(2);
    em = exp_mis(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (dut_in_a != 2'd2 && n < 100) begin
      tick();
      n++;
    end
    chk("s4_reach_pattern2", int'(n < 100), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s4_busy", int'(busy_a), 0);
    chk("s4_aborted", int'(aborted_a), 1);
    chk("s4_done", int'(done_a), 0);
    chk("s4_rec_valid", int'(rec_valid_a), 0);
    chk("s4_partial_cnt", int'(mcnt_a), em);
    repeat (6) tick();
    chk("s4_stays_idle", int'(busy_a), 0);
    chk("s4_queue_empty", exp_q.size(), 0);
    run_sweep("s4b", 0, 1'b0);

    // asynchronous reset while a record is pending
    randomize_tables(1'b1);
    push_sweep(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(rec_valid_a && rec_pattern_a == 2'd2) && n < 100) begin
      tick();
      n++;
    end
    chk("s5_reach_emit2", int'(n < 100), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("s5_rec_valid", int'(rec_valid_a), 0);
    chk("s5_busy", int'(busy_a), 0);
    chk("s5_dut_in", int'(dut_in_a), 0);
    chk("s5_done", int'(done_a), 0);
    chk("s5_aborted", int'(aborted_a), 0);
    chk("s5_undelivered", exp_q.size(), 2);
    exp_q.delete();
    @(negedge CK);
    reset = 1'b1;
    tick();
    run_sweep("s5b", 0, 1'b0);

    // zero settle with start held: two back-to-back sweeps
    start_b = 1'b1;
    repeat (20) tick();
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 200) begin
      tick();
      n++;
    end
    chk("b_finished", int'(n < 200), 1);
    chk("b_records", nrec_b, 8);
    chk("b_done", int'(done_b), 1);
    em = 0;
    for (int p = 0; p < 4; p++) em += int'(troj_b[p] != 2'b00);
    chk("b_mismatch_cnt", int'(mcnt_b), em);
    chk("b_trojan", int'(troj_flag_b), 1);
    repeat (4) tick();
    chk("b_no_restart", int'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
